uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Controller that sequences the UART receive engine (uart_receive) and exposes it to the CPU/Wishbone-side logic. It provides the programmable bit period (clk_div) and captures each received byte into an internal RX FIFO on the engine's done pulse. It releases the engine with the rx_finish handshake, or holds it with rx_full when the FIFO is full. It also counts framing errors and generates a level/error interrupt through a small register file.

Parameters:
- FIFO_DEPTH, 8, RX FIFO entries; power of two, 2..64.
- LVL_W, 4, level counter width; equals clog2(FIFO_DEPTH)+1.
- CLKDIV_RST, 32'd434, reset value of clk_div (115200 baud at 50 MHz).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- eng_rx_data  in  8  byte from engine, stable while engine waits for rx_finish
- eng_done  in  1  engine single-cycle byte-complete pulse
- eng_frame_err  in  1  engine single-cycle framing-error pulse
- eng_busy  in  1  engine receiving a frame
- eng_rx_finish  out  1  one-cycle release of engine after byte consumed
- eng_rx_full  out  1  level to engine: byte pending, FIFO full
- eng_clk_div  out  32  bit period in clk cycles
- reg_wr  in  1  register write strobe
- reg_rd  in  1  register read strobe
- reg_addr  in  3  word index
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data
- reg_ready  out  1  one-cycle access-complete pulse
- irq  out  1  level interrupt

Behaviour:
- Reset (rst_n=0 sampled on clk edge): state IDLE, FIFO empty, ferr_cnt=0, ctrl=0, eng_clk_div=CLKDIV_RST. eng_rx_finish=0, eng_rx_full=0, reg_rdata=0, reg_ready=0, irq=0. A reset mid-frame or in HOLD discards the pending byte. The engine resets in parallel.
- FSM states IDLE, HOLD, RELEASE:
  - IDLE: on eng_done with FIFO not full, push eng_rx_data in that cycle and go to RELEASE. On eng_done with FIFO full, go to HOLD.
  - HOLD: eng_rx_full=1. When the FIFO is not full (after a pop), push eng_rx_data and go to RELEASE. A pop and a push never land in the same entry cycle; the push uses next-cycle fullness.
  - RELEASE: eng_rx_finish=1 for exactly one cycle, then IDLE.
- Receive latency: done to byte visible in FIFO is 1 cycle; done to rx_finish is 1 cycle when not full.
- eng_done arriving while not in IDLE is a protocol violation: ignored, ovr sticky bit set.
- eng_frame_err pulse: ferr_cnt increments, saturating at 8'hFF; ferr sticky bit set. No FIFO push.
- Registers (index):
  - 0 DATA (read): pops the FIFO head into rdata[7:0]. Reading when empty returns 0, no state change.
  - 1 STATUS (read): {16'b0, level[7:0], 3'b0, ovr, ferr, eng_busy, full, empty}.
  - 2 CTRL (rw): [0] irq_lvl_en, [1] irq_ferr_en, [15:8] threshold (0 treated as 1).
  - 3 CLKDIV (rw): written values below 16 clamp to 16.
  - 4 FERR_CNT (read): count in [7:0]. Any write clears the count and both sticky bits.
  - Other indices read 0; writes to them are ignored.
- Access timing: reg_ready pulses the cycle after reg_rd or reg_wr, and reg_rdata is valid in that same cycle. reg_rd and reg_wr asserted together: the write wins and no pop occurs.
- A pop and a push in the same cycle are both performed and the level is unchanged. Pointers wrap modulo FIFO_DEPTH.
- irq = (irq_lvl_en & level>=threshold) | (irq_ferr_en & ferr). irq is registered and updates one cycle after its cause.
- A CLKDIV write while eng_busy=1 takes effect on eng_clk_div immediately; software must write only while idle.

Decomposition:
- Package uart_rx_pkg: register index constants, CTRL bit positions, FSM state encoding (2 bits), CLKDIV_MIN=16.
- Sub-module sync_fifo (parameterised DEPTH/WIDTH; push, pop, full, empty, level, registered head data).
- FSM, register file and irq logic stay in uart_rx_ctrl.

Test Plan:
- Single byte: done with 0xA5 → level=1 next cycle; rx_finish one cycle later; read idx0 → 0xA5, then level=0, empty=1.
- Fill 8 bytes 0x00..0x07, then a 9th byte 0x08 → HOLD with rx_full=1 and no rx_finish. Read idx0 → 0x00; next cycle 0x08 is pushed and rx_finish pulses. Following reads return 0x01..0x08 in order.
- Threshold=3, irq_lvl_en=1: after 2 bytes irq=0; after the 3rd irq=1 one cycle later; one pop → irq=0.
- Three frame_err pulses → FERR_CNT=3, ferr=1; with irq_ferr_en=1, irq=1. Write idx4 → count 0, irq=0. 300 pulses → count saturates at 255.
- CLKDIV write of 5 → reads back 16; write of 868 → eng_clk_div=868. Read of idx6 → 0.
- Reset asserted while in HOLD with FIFO full → next cycle empty=1, rx_full=0, irq=0, clk_div=434; a pop and a push in the same cycle keep level unchanged.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive controller.
//   - register word indices on the CPU-side register port
//   - CTRL register bit positions
//   - controller FSM state encoding (2 bits)
//   - minimum legal bit period and the clamp helper applied to CLKDIV writes
package uart_rx_pkg;

  localparam logic [2:0] REG_DATA     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_CTRL     = 3'd2;
  localparam logic [2:0] REG_CLKDIV   = 3'd3;
  localparam logic [2:0] REG_FERR_CNT = 3'd4;

  localparam int CTRL_IRQ_LVL_EN  = 0;
  localparam int CTRL_IRQ_FERR_EN = 1;
  localparam int CTRL_THR_LSB     = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [31:0] CLKDIV_MIN = 32'd16;

  function automatic logic [31:0] clamp_clkdiv(input logic [31:0] value);
    return (value < CLKDIV_MIN) ? CLKDIV_MIN : value;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Synchronous FIFO holding received bytes.
// Ports:
//   clk, rst_n     system clock, synchronous active-low reset (pointers/level only)
//   push, wdata    write request and data; ignored when full unless a pop frees a slot
//   pop            read request; ignored when empty
//   head           entry at the read pointer, taken straight from the storage registers
//   full, empty    occupancy flags
//   level          number of stored entries (0..DEPTH)
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int LVL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO can still accept a push when the same cycle pops.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sequences the uart_receive engine, buffers received
// bytes in a FIFO and exposes them through a small register file with interrupt.
// Ports:
//   clk, rst_n                   system clock, synchronous active-low reset
//   eng_rx_data/done/frame_err   byte, byte-complete pulse, framing-error pulse from engine
//   eng_busy                     engine is receiving a frame
//   eng_rx_finish                one-cycle release of the engine after its byte is stored
//   eng_rx_full                  held while a byte is pending and the FIFO is full
//   eng_clk_div                  bit period in clk cycles
//   reg_wr/rd/addr/wdata         register access request (word index)
//   reg_rdata, reg_ready         read data and access-complete pulse, one cycle later
//   irq                          level interrupt (FIFO level and/or framing error)
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter int          LVL_W      = 4,
  parameter logic [31:0] CLKDIV_RST = 32'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  eng_rx_data,
  input  logic        eng_done,
  input  logic        eng_frame_err,
  input  logic        eng_busy,
  output logic        eng_rx_finish,
  output logic        eng_rx_full,
  output logic [31:0] eng_clk_div,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [2:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        reg_ready,
  output logic        irq
);

  logic [1:0]       state;
  logic             fifo_push;
  logic             fifo_pop;
  logic [7:0]       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic [7:0]       level8;
  logic             irq_lvl_en;
  logic             irq_ferr_en;
  logic [7:0]       threshold;
  logic [7:0]       thr_eff;
  logic [7:0]       ferr_cnt;
  logic             ferr;
  logic             ovr;
  logic             rd_access;
  logic [31:0]      rd_mux;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (eng_rx_data),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign eng_rx_finish = (state == ST_RELEASE);
  assign eng_rx_full   = (state == ST_HOLD);

  // A simultaneous write takes priority, so only a pure read may pop.
  assign rd_access = reg_rd & ~reg_wr;
  assign fifo_pop  = rd_access & (reg_addr == REG_DATA);
  assign level8    = 8'(fifo_level);
  assign thr_eff   = (threshold == 8'd0) ? 8'd1 : threshold;

  // HOLD looks at the registered full flag, so a pop lands one cycle before the push.
  always_comb begin
    fifo_push = 1'b0;
    case (state)
      ST_IDLE: fifo_push = eng_done & ~fifo_full;
      ST_HOLD: fifo_push = ~fifo_full;
      default: fifo_push = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (eng_done) state <= fifo_full ? ST_HOLD : ST_RELEASE;
        ST_HOLD:    if (!fifo_full) state <= ST_RELEASE;
        ST_RELEASE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (reg_addr)
      REG_DATA:     rd_mux = fifo_empty ? 32'd0 : {24'd0, fifo_head};
      REG_STATUS:   rd_mux = {16'd0, level8, 3'd0, ovr, ferr, eng_busy, fifo_full, fifo_empty};
      REG_CTRL:     rd_mux = {16'd0, threshold, 6'd0, irq_ferr_en, irq_lvl_en};
      REG_CLKDIV:   rd_mux = eng_clk_div;
      REG_FERR_CNT: rd_mux = {24'd0, ferr_cnt};
      default:      rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_ready   <= 1'b0;
      reg_rdata   <= 32'd0;
      irq_lvl_en  <= 1'b0;
      irq_ferr_en <= 1'b0;
      threshold   <= 8'd0;
      eng_clk_div <= CLKDIV_RST;
      ferr_cnt    <= 8'd0;
      ferr        <= 1'b0;
      ovr         <= 1'b0;
      irq         <= 1'b0;
    end else begin
      reg_ready <= reg_rd | reg_wr;
      reg_rdata <= rd_access ? rd_mux : 32'd0;
      irq       <= (irq_lvl_en & (level8 >= thr_eff)) | (irq_ferr_en & ferr);

      if (eng_frame_err) begin
        ferr <= 1'b1;
        if (ferr_cnt != 8'hFF) ferr_cnt <= ferr_cnt + 8'd1;
      end
      if (eng_done && state != ST_IDLE) ovr <= 1'b1;

      // Register writes come last so a clear wins over a same-cycle event.
      if (reg_wr) begin
        case (reg_addr)
          REG_CTRL: begin
            irq_lvl_en  <= reg_wdata[CTRL_IRQ_LVL_EN];
            irq_ferr_en <= reg_wdata[CTRL_IRQ_FERR_EN];
            threshold   <= reg_wdata[CTRL_THR_LSB +: 8];
          end
          REG_CLKDIV: eng_clk_div <= clamp_clkdiv(reg_wdata);
          REG_FERR_CNT: begin
            ferr_cnt <= 8'd0;
            ferr     <= 1'b0;
            ovr      <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed stimulus with a scoreboard. Register reads
// push their expected data into a queue that a monitor pops on reg_ready; level
// checks on engine/irq outputs are queued as probes evaluated on the falling edge.
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  eng_rx_data;
  logic        eng_done;
  logic        eng_frame_err;
  logic        eng_busy;
  logic        eng_rx_finish;
  logic        eng_rx_full;
  logic [31:0] eng_clk_div;
  logic        reg_wr;
  logic        reg_rd;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_ready;
  logic        irq;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .FIFO_DEPTH (8),
    .LVL_W      (4),
    .CLKDIV_RST (32'd434)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .eng_rx_data   (eng_rx_data),
    .eng_done      (eng_done),
    .eng_frame_err (eng_frame_err),
    .eng_busy      (eng_busy),
    .eng_rx_finish (eng_rx_finish),
    .eng_rx_full   (eng_rx_full),
    .eng_clk_div   (eng_clk_div),
    .reg_wr        (reg_wr),
    .reg_rd        (reg_rd),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_rdata     (reg_rdata),
    .reg_ready     (reg_ready),
    .irq           (irq)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          chk;
  } rd_exp_t;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } probe_t;

  localparam int SIG_FINISH = 0;
  localparam int SIG_FULL   = 1;
  localparam int SIG_IRQ    = 2;
  localparam int SIG_CLKDIV = 3;

  rd_exp_t rdq[$];
  probe_t  prq[$];
  int      checks = 0;
  int      errors = 0;
  bit      finish_req = 1'b0;

  function automatic logic [31:0] sample(input int sig);
    case (sig)
      SIG_FINISH: return {31'd0, eng_rx_finish};
      SIG_FULL:   return {31'd0, eng_rx_full};
      SIG_IRQ:    return {31'd0, irq};
      default:    return eng_clk_div;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input string n, input int s, input logic [31:0] e);
    prq.push_back('{name: n, sig: s, exp: e});
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
    reg_addr = a;
    reg_rd   = 1'b1;
    rdq.push_back('{name: n, exp: e, chk: 1'b1});
    tick();
    reg_rd = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    reg_addr  = a;
    reg_wdata = d;
    reg_wr    = 1'b1;
    rdq.push_back('{name: "write", exp: 32'd0, chk: 1'b0});
    tick();
    reg_wr = 1'b0;
  endtask

  task automatic byte_in(input logic [7:0] b);
    eng_rx_data = b;
    eng_done    = 1'b1;
    tick();
    eng_done = 1'b0;
  endtask

  task automatic ferr_pulse();
    eng_frame_err = 1'b1;
    tick();
    eng_frame_err = 1'b0;
  endtask

  // Monitor / scoreboard
  initial begin
    probe_t      p;
    rd_exp_t     r;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (prq.size() > 0) begin
        p   = prq.pop_front();
        act = sample(p.sig);
        checks++;
        if (act !== p.exp) begin
          errors++;
          $display("FAIL %s: got %0h, expected %0h", p.name, act, p.exp);
        end
      end
      if (reg_ready) begin
        if (rdq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got ready with rdata %0h, expected no access", reg_rdata);
        end else begin
          r = rdq.pop_front();
          if (r.chk) begin
            checks++;
            if (reg_rdata !== r.exp) begin
              errors++;
              $display("FAIL %s: got %0h, expected %0h", r.name, reg_rdata, r.exp);
            end
          end
        end
      end
      if (finish_req) begin
        checks++;
        if (rdq.size() != 0 || prq.size() != 0) begin
          errors++;
          $display("FAIL pending_accesses: got %0d reads and %0d probes outstanding, expected 0",
                   rdq.size(), prq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    rst_n = 1'b0; eng_rx_data = 8'd0; eng_done = 1'b0; eng_frame_err = 1'b0; eng_busy = 1'b0;
    reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = 3'd0; reg_wdata = 32'd0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset state
    probe("rst_finish", SIG_FINISH, 0);
    probe("rst_full", SIG_FULL, 0);
    probe("rst_irq", SIG_IRQ, 0);
    probe("rst_clkdiv", SIG_CLKDIV, 434);
    rd(REG_STATUS, 32'h1, "status_rst");
    rd(REG_DATA, 32'h0, "data_empty");
    rd(REG_CTRL, 32'h0, "ctrl_rst");
    rd(REG_FERR_CNT, 32'h0, "ferr_rst");
    eng_busy = 1'b1;
    rd(REG_STATUS, 32'h5, "status_busy");
    eng_busy = 1'b0;

    // Single byte
    byte_in(8'hA5);
    probe("single_finish", SIG_FINISH, 1);
    probe("single_full", SIG_FULL, 0);
    rd(REG_STATUS, 32'h100, "status_one");
    probe("single_finish_end", SIG_FINISH, 0);
    rd(REG_DATA, 32'hA5, "data_a5");
    rd(REG_STATUS, 32'h1, "status_drained");

    // Fill to full, then a ninth byte waits in HOLD
    for (int i = 0; i < 8; i++) begin
      byte_in(8'(i));
      tick();
    end
    byte_in(8'h08);
    probe("hold_full", SIG_FULL, 1);
    probe("hold_no_finish", SIG_FINISH, 0);
    rd(REG_STATUS, 32'h0802, "status_full");
    probe("hold_full_2", SIG_FULL, 1);
    rd(REG_DATA, 32'h00, "pop_in_hold");
    probe("hold_push_full", SIG_FULL, 1);
    probe("hold_push_no_finish", SIG_FINISH, 0);
    tick();
    probe("hold_release_finish", SIG_FINISH, 1);
    probe("hold_release_full", SIG_FULL, 0);
    tick();
    for (int i = 1; i <= 8; i++) rd(REG_DATA, 32'(i), "fifo_order");
    rd(REG_STATUS, 32'h1, "status_after_fill");

    // done while in RELEASE is ignored and flags overrun
    byte_in(8'h55);
    byte_in(8'h66);
    rd(REG_STATUS, 32'h110, "status_ovr");
    rd(REG_DATA, 32'h55, "data_ovr");
    rd(REG_STATUS, 32'h11, "status_ovr_empty");
    wr(REG_FERR_CNT, 32'h0);
    rd(REG_STATUS, 32'h1, "status_ovr_clr");

    // Level interrupt, threshold 3
    wr(REG_CTRL, 32'h0301);
    rd(REG_CTRL, 32'h0301, "ctrl_readback");
    byte_in(8'h01); tick();
    byte_in(8'h02); tick(); tick();
    probe("irq_two_bytes", SIG_IRQ, 0);
    byte_in(8'h03);
    probe("irq_same_cycle", SIG_IRQ, 0);
    tick();
    probe("irq_three_bytes", SIG_IRQ, 1);
    rd(REG_DATA, 32'h01, "irq_pop1");
    probe("irq_pop_lag", SIG_IRQ, 1);
    tick();
    probe("irq_after_pop", SIG_IRQ, 0);
    rd(REG_DATA, 32'h02, "irq_pop2");
    rd(REG_DATA, 32'h03, "irq_pop3");

    // Threshold 0 behaves as 1
    wr(REG_CTRL, 32'h0001);
    tick();
    probe("thr0_empty", SIG_IRQ, 0);
    byte_in(8'h09); tick();
    probe("thr0_one", SIG_IRQ, 1);
    rd(REG_DATA, 32'h09, "thr0_pop");
    tick();
    probe("thr0_drained", SIG_IRQ, 0);
    wr(REG_CTRL, 32'h0);

    // Framing errors
    repeat (3) ferr_pulse();
    rd(REG_FERR_CNT, 32'h3, "ferr_three");
    rd(REG_STATUS, 32'h9, "status_ferr");
    wr(REG_CTRL, 32'h2);
    tick();
    probe("irq_ferr", SIG_IRQ, 1);
    wr(REG_FERR_CNT, 32'h0);
    tick();
    probe("irq_ferr_clr", SIG_IRQ, 0);
    rd(REG_FERR_CNT, 32'h0, "ferr_cleared");
    eng_frame_err = 1'b1;
    repeat (300) tick();
    eng_frame_err = 1'b0;
    rd(REG_FERR_CNT, 32'hFF, "ferr_saturate");
    wr(REG_FERR_CNT, 32'h0);
    wr(REG_CTRL, 32'h0);

    // Clock divider
    wr(REG_CLKDIV, 32'd5);
    probe("clkdiv_clamp", SIG_CLKDIV, 16);
    rd(REG_CLKDIV, 32'd16, "clkdiv_clamp_rd");
    wr(REG_CLKDIV, 32'd868);
    probe("clkdiv_868", SIG_CLKDIV, 868);
    rd(REG_CLKDIV, 32'd868, "clkdiv_868_rd");
    rd(3'd6, 32'h0, "idx6_read");
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, 32'h0, "idx6_after_write");
    rd(REG_CTRL, 32'h0, "ctrl_untouched");

    // Read and write together: write wins, no pop
    byte_in(8'h3C); tick();
    reg_addr = REG_DATA; reg_wdata = 32'h0; reg_rd = 1'b1; reg_wr = 1'b1;
    rdq.push_back('{name: "rdwr", exp: 32'd0, chk: 1'b0});
    tick();
    reg_rd = 1'b0; reg_wr = 1'b0;
    rd(REG_STATUS, 32'h100, "rdwr_no_pop");
    rd(REG_DATA, 32'h3C, "rdwr_data_kept");

    // Reset while holding a byte with the FIFO full
    wr(REG_CTRL, 32'h0101);
    for (int i = 0; i < 8; i++) begin
      byte_in(8'h10 + 8'(i));
      tick();
    end
    byte_in(8'h18);
    probe("pre_rst_full", SIG_FULL, 1);
    probe("pre_rst_irq", SIG_IRQ, 1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    probe("rst_hold_full", SIG_FULL, 0);
    probe("rst_hold_irq", SIG_IRQ, 0);
    probe("rst_hold_clkdiv", SIG_CLKDIV, 434);
    probe("rst_hold_finish", SIG_FINISH, 0);
    rd(REG_STATUS, 32'h1, "rst_hold_status");
    rd(REG_CTRL, 32'h0, "rst_hold_ctrl");

    // Pop and push in the same cycle keep the level
    byte_in(8'h21); tick();
    byte_in(8'h22); tick();
    reg_addr = REG_DATA; reg_rd = 1'b1;
    rdq.push_back('{name: "pushpop_data", exp: 32'h21, chk: 1'b1});
    eng_rx_data = 8'h23; eng_done = 1'b1;
    tick();
    reg_rd = 1'b0; eng_done = 1'b0;
    probe("pushpop_finish", SIG_FINISH, 1);
    tick();
    rd(REG_STATUS, 32'h200, "pushpop_level");
    rd(REG_DATA, 32'h22, "pushpop_d22");
    rd(REG_DATA, 32'h23, "pushpop_d23");
    rd(REG_STATUS, 32'h1, "pushpop_empty");

    for (int i = 0; i < 50 && (rdq.size() > 0 || prq.size() > 0); i++) tick();
    finish_req = 1'b1;
  end

endmodule
